uart_send_queue: RTL and testbench

Buffered, multi-source byte sender feeding the UART transmitter. It accepts one-cycle byte strobes from `NUM_SRC` producers, such as keyboard ASCII and the switch/button path, and holds one pending byte per source so simultaneous strobes are never lost. It queues the bytes in a `DEPTH`-entry FIFO, optionally inserts a language-change marker byte, and drains the queue one frame at a time using the UART `tx_busy` handshake. It replaces ad-hoc single-register send logic at the top of the sender design.

---
 rtl/uart_send_queue_pkg.sv | 18 +
 rtl/uart_send_queue_sync_fifo.sv | 51 +++++
 rtl/uart_send_queue.sv | 144 ++++++++++++++
 tb/tb_uart_send_queue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_send_queue_pkg.sv
// rtl/uart_send_queue_pkg.sv - shared constants, drain states and width helper for uart_send_queue
package uart_send_queue_pkg;

   localparam logic [7:0] LANG_MARK_TH = 8'h0E;
   localparam logic [7:0] LANG_MARK_EN = 8'h0F;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } drain_state_e;

   // Occupancy counters need one extra bit so that "full" is distinguishable from "empty".
   function automatic int count_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_send_queue_sync_fifo.sv
// rtl/uart_send_queue_sync_fifo.sv - circular-buffer FIFO with extended pointers and combinational head
module sync_fifo
   import uart_send_queue_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push,
   input  logic                        pop,
   input  logic [DATA_W-1:0]           din,
   output logic [DATA_W-1:0]           dout,
   output logic [count_w(DEPTH)-1:0]   count,
   output logic                        full,
   output logic                        empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = count_w(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign count = CW'(wr_ptr - rd_ptr);
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is deliberately not reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_send_queue.sv
// rtl/uart_send_queue.sv - multi-source pending stage, language marker, FIFO and UART drain FSM
module uart_send_queue
   import uart_send_queue_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 16,
   parameter int NUM_SRC     = 2,
   parameter int PREFIX_LANG = 1,
   parameter int BUSY_TO     = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_SRC*DATA_W-1:0]   src_data,
   input  logic [NUM_SRC-1:0]          src_valid,
   input  logic                        is_thai,
   input  logic                        tx_busy,
   output logic [DATA_W-1:0]           tx_data,
   output logic                        tx_start,
   output logic [count_w(DEPTH)-1:0]   count,
   output logic                        empty,
   output logic                        full,
   output logic                        dropped
);

   localparam int CW   = count_w(DEPTH);
   localparam int SW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int TO_W = $clog2(BUSY_TO + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);

   localparam logic [1:0] S_IDLE      = IDLE;
   localparam logic [1:0] S_WAIT_BUSY = WAIT_BUSY;
   localparam logic [1:0] S_WAIT_DONE = WAIT_DONE;

   logic [DATA_W-1:0] pend_data [NUM_SRC];
   logic [NUM_SRC-1:0] pend_v;
   logic              last_lang;

   logic              any_pend;
   logic [SW-1:0]     sel;
   logic [CW-1:0]     free_slots;
   logic              need_mark;
   logic              wr_mark;
   logic              wr_data;
   logic              fifo_push;
   logic              fifo_pop;
   logic [DATA_W-1:0] fifo_din;
   logic [DATA_W-1:0] fifo_dout;

   logic [1:0]        state;
   logic [TO_W-1:0]   to_cnt;

   // Priority pick: scanning downward leaves the lowest pending index selected.
   always_comb begin
      any_pend = 1'b0;
      sel      = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pend_v[i]) begin
            any_pend = 1'b1;
            sel      = SW'(i);
         end
      end
   end

   assign free_slots = CW'(DEPTH) - count;
   assign need_mark  = (PREFIX_LANG != 0) && (is_thai != last_lang);
   // A marker needs room for itself and the byte that follows it.
   assign wr_mark    = any_pend && need_mark && (free_slots >= CW'(2));
   assign wr_data    = any_pend && !need_mark && !full;
   assign fifo_push  = wr_mark || wr_data;

   always_comb begin
      fifo_din = pend_data[sel];
      if (wr_mark) fifo_din = is_thai ? DATA_W'(LANG_MARK_TH) : DATA_W'(LANG_MARK_EN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_v    <= '0;
         dropped   <= 1'b0;
         last_lang <= 1'b0;
         for (int i = 0; i < NUM_SRC; i++) pend_data[i] <= '0;
      end else begin
         if (wr_mark) last_lang <= is_thai;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i]) begin
               pend_data[i] <= src_data[i*DATA_W +: DATA_W];
               pend_v[i]    <= 1'b1;
               if (pend_v[i] && !(wr_data && (sel == SW'(i)))) dropped <= 1'b1;
            end else if (wr_data && (sel == SW'(i))) begin
               pend_v[i] <= 1'b0;
            end
         end
      end
   end

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign fifo_pop = (state == S_IDLE) && !empty && !tx_busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         tx_start <= 1'b0;
         tx_data  <= '0;
         to_cnt   <= '0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (fifo_pop) begin
                  tx_data  <= fifo_dout;
                  tx_start <= 1'b1;
                  to_cnt   <= '0;
                  state    <= S_WAIT_BUSY;
               end
            end
            S_WAIT_BUSY: begin
               // A UART that never acknowledges still lets the queue move on.
               if (tx_busy)                 state <= S_WAIT_DONE;
               else if (to_cnt == TO_LAST)  state <= S_IDLE;
               else                         to_cnt <= to_cnt + 1'b1;
            end
            S_WAIT_DONE: begin
               if (!tx_busy) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_send_queue.sv
// tb/tb_uart_send_queue.sv - directed table-driven bench for uart_send_queue
module tb_uart_send_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] src_data;
   logic [1:0]  src_valid;
   logic        is_thai;
   logic        tx_busy;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic [4:0]  count;
   logic        empty;
   logic        full;
   logic        dropped;

   int checks = 0;
   int errors = 0;

   logic       uart_busy  = 1'b0;
   logic       busy_force = 1'b0;
   logic       uart_auto  = 1'b1;
   logic       prev_start = 1'b0;
   int         busy_cnt   = 0;
   int         frame_len  = 4;
   logic [7:0] sent [$];

   typedef struct {
      logic [1:0] mask;
      logic [7:0] b0;
      logic [7:0] b1;
      logic       thai;
      int         n;
      logic [7:0] e [3];
   } vec_t;

   vec_t vecs [6];

   assign tx_busy = uart_busy | busy_force;

   always #5 clk = ~clk;

   uart_send_queue dut (
      .clk       (clk),
      .reset     (reset),
      .src_data  (src_data),
      .src_valid (src_valid),
      .is_thai   (is_thai),
      .tx_busy   (tx_busy),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .dropped   (dropped)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      src_valid = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic strobe(input logic [1:0] m, input logic [7:0] b0, input logic [7:0] b1);
      src_data  = {b1, b0};
      src_valid = m;
      tick();
      src_valid = '0;
   endtask

   // UART model: records every frame and raises busy for frame_len cycles.
   always @(negedge clk) begin
      if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) uart_busy = 1'b0;
      end
      if (tx_start === 1'b1) begin
         chk("start_while_busy", 32'(tx_busy), 32'd0);
         chk("start_adjacent", 32'(prev_start), 32'd0);
         sent.push_back(tx_data);
         if (uart_auto) begin
            uart_busy = 1'b1;
            busy_cnt  = frame_len;
         end
      end
      prev_start = tx_start;
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int e;
      logic [7:0] exp_b;

      vecs[0] = '{2'b01, 8'h41, 8'h00, 1'b0, 1, '{8'h41, 8'h00, 8'h00}};
      vecs[1] = '{2'b10, 8'h00, 8'h55, 1'b0, 1, '{8'h55, 8'h00, 8'h00}};
      vecs[2] = '{2'b11, 8'h31, 8'h32, 1'b0, 2, '{8'h31, 8'h32, 8'h00}};
      vecs[3] = '{2'b01, 8'hA1, 8'h00, 1'b1, 2, '{8'h0E, 8'hA1, 8'h00}};
      vecs[4] = '{2'b10, 8'h00, 8'hA2, 1'b1, 1, '{8'hA2, 8'h00, 8'h00}};
      vecs[5] = '{2'b01, 8'h42, 8'h00, 1'b0, 2, '{8'h0F, 8'h42, 8'h00}};

      reset = 1'b1;
      src_valid = '0;
      src_data = '0;
      is_thai = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_dropped", 32'(dropped), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // Latency: strobe in cycle t, tx_start in cycle t+3.
      sent.delete();
      strobe(2'b01, 8'h41, 8'h00);
      tick();
      @(negedge clk);
      chk("lat_t2_start", 32'(tx_start), 32'd0);
      tick();
      @(negedge clk);
      chk("lat_t3_start", 32'(tx_start), 32'd1);
      chk("lat_t3_data", 32'(tx_data), 32'h41);
      repeat (20) tick();
      chk("lat_count", 32'(count), 32'd0);
      chk("lat_empty", 32'(empty), 32'd1);
      chk("lat_sent_n", 32'(sent.size()), 32'd1);

      for (int v = 0; v < 6; v++) begin
         sent.delete();
         is_thai = vecs[v].thai;
         strobe(vecs[v].mask, vecs[v].b0, vecs[v].b1);
         repeat (40) tick();
         chk($sformatf("vec%0d_n", v), 32'(sent.size()), 32'(vecs[v].n));
         for (int j = 0; j < vecs[v].n; j++)
            chk($sformatf("vec%0d_b%0d", v, j),
                (j < sent.size()) ? 32'(sent[j]) : 32'hDEAD, 32'(vecs[v].e[j]));
      end
      chk("vec_dropped", 32'(dropped), 32'd0);

      // Full FIFO: 18 strobes, the 18th overwrites the 17th still pending.
      do_reset();
      is_thai = 1'b0;
      sent.delete();
      busy_force = 1'b1;
      for (int k = 0; k < 18; k++) begin
         strobe(2'b01, 8'h80 + 8'(k), 8'h00);
         tick();
      end
      @(negedge clk);
      chk("full_flag", 32'(full), 32'd1);
      chk("full_count", 32'(count), 32'd16);
      chk("full_empty", 32'(empty), 32'd0);
      chk("full_dropped", 32'(dropped), 32'd1);
      tick();
      busy_force = 1'b0;
      for (int c = 0; c < 2000 && sent.size() < 17; c++) tick();
      repeat (30) tick();
      chk("full_sent_n", 32'(sent.size()), 32'd17);
      for (int k = 0; k < 17; k++) begin
         exp_b = (k < 16) ? 8'h80 + 8'(k) : 8'h91;
         chk($sformatf("full_b%0d", k), (k < sent.size()) ? 32'(sent[k]) : 32'hDEAD, 32'(exp_b));
      end
      chk("full_drained", 32'(empty), 32'd1);

      // Busy timeout: the UART never raises busy.
      do_reset();
      sent.delete();
      uart_auto = 1'b0;
      strobe(2'b01, 8'h61, 8'h00);
      strobe(2'b01, 8'h62, 8'h00);
      s = -1;
      e = -1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            if (s < 0) s = c;
            else begin
               e = c;
               break;
            end
         end
      end
      chk("timeout_first_seen", 32'(s >= 0), 32'd1);
      chk("timeout_gap", 32'(e - s), 32'd17);
      tick();
      chk("timeout_b1", (sent.size() > 1) ? 32'(sent[1]) : 32'hDEAD, 32'h62);
      uart_auto = 1'b1;
      repeat (30) tick();

      // Reset mid-operation: one frame in flight, five bytes queued.
      do_reset();
      sent.delete();
      frame_len = 60;
      strobe(2'b01, 8'h71, 8'h00);
      repeat (5) tick();
      for (int k = 0; k < 5; k++) begin
         strobe(2'b01, 8'h72 + 8'(k), 8'h00);
         tick();
      end
      @(negedge clk);
      chk("mid_count", 32'(count), 32'd5);
      chk("mid_sent_n", 32'(sent.size()), 32'd1);
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("mrst_count", 32'(count), 32'd0);
      chk("mrst_empty", 32'(empty), 32'd1);
      chk("mrst_tx_start", 32'(tx_start), 32'd0);
      chk("mrst_dropped", 32'(dropped), 32'd0);
      tick();
      reset = 1'b0;
      sent.delete();
      repeat (100) tick();
      chk("mrst_no_send", 32'(sent.size()), 32'd0);
      chk("mrst_count_after", 32'(count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
